// File: rtl/cr16_regfile_mp.sv
// rtl/cr16_regfile_mp.sv - multi-port CR16 register file with pending-write scoreboard
module cr16_regfile_mp #(
    parameter int P_REG_WIDTH  = 16,
    parameter int P_FILE_WIDTH = 16,
    parameter int P_READ_PORTS = 2,
    parameter int P_BYPASS     = 1,
    localparam int AW          = $clog2(P_FILE_WIDTH)
) (
    input  logic                    I_CLK,
    input  logic                    I_NRESET,
    input  logic                    I_WR_EN,
    input  logic [AW-1:0]           I_WR_ADDR,
    input  logic [P_REG_WIDTH-1:0]  I_WR_DATA,
    input  logic                    I_RSV_EN,
    input  logic [AW-1:0]           I_RSV_ADDR,
    input  logic [AW-1:0]           I_RD_ADDR   [P_READ_PORTS],
    output logic [P_REG_WIDTH-1:0]  O_RD_DATA   [P_READ_PORTS],
    output logic [P_READ_PORTS-1:0] O_RD_BUSY,
    output logic [P_FILE_WIDTH-1:0] O_BUSY_MASK,
    output logic                    O_RSV_OVERLAP,
    output logic [P_REG_WIDTH-1:0]  O_REG_DATA  [P_FILE_WIDTH]
);

    logic [P_REG_WIDTH-1:0]  regs [P_FILE_WIDTH];
    logic [P_FILE_WIDTH-1:0] busy;
    logic [P_FILE_WIDTH-1:0] busy_nxt;
    logic                    overlap;
    logic                    overlap_nxt;
    logic [P_READ_PORTS-1:0] fwd;

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            for (int i = 0; i < P_FILE_WIDTH; i++) begin
                regs[i] <= '0;
            end
        end else if (I_WR_EN) begin
            regs[I_WR_ADDR] <= I_WR_DATA;
        end
    end

    // A reserve in the same cycle as a retiring write belongs to a newer
    // instruction, so it takes priority over the clear.
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < P_FILE_WIDTH; i++) begin
            if (I_RSV_EN && (I_RSV_ADDR == AW'(i))) begin
                busy_nxt[i] = 1'b1;
            end else if (I_WR_EN && (I_WR_ADDR == AW'(i))) begin
                busy_nxt[i] = 1'b0;
            end
        end
        overlap_nxt = I_RSV_EN & busy[I_RSV_ADDR] & ~(I_WR_EN & (I_WR_ADDR == I_RSV_ADDR));
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            busy    <= '0;
            overlap <= 1'b0;
        end else begin
            busy    <= busy_nxt;
            overlap <= overlap_nxt;
        end
    end

    always_comb begin
        fwd = '0;
        for (int n = 0; n < P_READ_PORTS; n++) begin
            fwd[n]       = (P_BYPASS != 0) && I_WR_EN && (I_RD_ADDR[n] == I_WR_ADDR);
            O_RD_DATA[n] = fwd[n] ? I_WR_DATA : regs[I_RD_ADDR[n]];
            O_RD_BUSY[n] = fwd[n] ? 1'b0 : busy[I_RD_ADDR[n]];
        end
    end

    assign O_BUSY_MASK   = busy;
    assign O_RSV_OVERLAP = overlap;
    assign O_REG_DATA    = regs;

endmodule

// File: tb/tb_cr16_regfile_mp.sv
// tb/tb_cr16_regfile_mp.sv - directed and model-checked bench for cr16_regfile_mp
module tb_cr16_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        wr_en, rsv_en;
    logic [3:0]  wr_addr, rsv_addr;
    logic [15:0] wr_data;
    logic [3:0]  rd_addr [2];

    logic [15:0] rd_data_b [2], rd_data_n [2];
    logic [1:0]  rd_busy_b, rd_busy_n;
    logic [15:0] busy_mask_b, busy_mask_n;
    logic        ovl_b, ovl_n;
    logic [15:0] reg_data_b [16], reg_data_n [16];

    logic        w_wr_en, w_rsv_en;
    logic [2:0]  w_wr_addr, w_rsv_addr;
    logic [31:0] w_wr_data;
    logic [2:0]  w_rd_addr [3];
    logic [31:0] w_rd_data [3];
    logic [2:0]  w_rd_busy;
    logic [7:0]  w_busy_mask;
    logic        w_ovl;
    logic [31:0] w_reg_data [8];

    int n_cmp = 0;
    int n_err = 0;

    cr16_regfile_mp #(.P_REG_WIDTH(16), .P_FILE_WIDTH(16), .P_READ_PORTS(2), .P_BYPASS(1)) u_byp (
        .I_CLK(clk), .I_NRESET(rst_n), .I_WR_EN(wr_en), .I_WR_ADDR(wr_addr), .I_WR_DATA(wr_data),
        .I_RSV_EN(rsv_en), .I_RSV_ADDR(rsv_addr), .I_RD_ADDR(rd_addr), .O_RD_DATA(rd_data_b),
        .O_RD_BUSY(rd_busy_b), .O_BUSY_MASK(busy_mask_b), .O_RSV_OVERLAP(ovl_b), .O_REG_DATA(reg_data_b)
    );

    cr16_regfile_mp #(.P_REG_WIDTH(16), .P_FILE_WIDTH(16), .P_READ_PORTS(2), .P_BYPASS(0)) u_nobyp (
        .I_CLK(clk), .I_NRESET(rst_n), .I_WR_EN(wr_en), .I_WR_ADDR(wr_addr), .I_WR_DATA(wr_data),
        .I_RSV_EN(rsv_en), .I_RSV_ADDR(rsv_addr), .I_RD_ADDR(rd_addr), .O_RD_DATA(rd_data_n),
        .O_RD_BUSY(rd_busy_n), .O_BUSY_MASK(busy_mask_n), .O_RSV_OVERLAP(ovl_n), .O_REG_DATA(reg_data_n)
    );

    cr16_regfile_mp #(.P_REG_WIDTH(32), .P_FILE_WIDTH(8), .P_READ_PORTS(3), .P_BYPASS(1)) u_wide (
        .I_CLK(clk), .I_NRESET(rst_n), .I_WR_EN(w_wr_en), .I_WR_ADDR(w_wr_addr), .I_WR_DATA(w_wr_data),
        .I_RSV_EN(w_rsv_en), .I_RSV_ADDR(w_rsv_addr), .I_RD_ADDR(w_rd_addr), .O_RD_DATA(w_rd_data),
        .O_RD_BUSY(w_rd_busy), .O_BUSY_MASK(w_busy_mask), .O_RSV_OVERLAP(w_ovl), .O_REG_DATA(w_reg_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] m_reg [8];
    logic [7:0]  m_busy, m_busy_nxt;
    logic        m_ovl;
    logic        m_fwd;

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        rd_addr[0] = '0; rd_addr[1] = '0;
        w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
        w_rsv_en = 1'b0; w_rsv_addr = '0;
        for (int n = 0; n < 3; n++) w_rd_addr[n] = '0;

        tick(); tick();
        chk("rst_busy", busy_mask_b, 16'h0);
        chk("rst_ovl", ovl_b, 1'b0);
        chk("rst_rd0", rd_data_b[0], 16'h0);
        rst_n = 1'b1;
        tick();

        // Build up nonzero state, then reset asynchronously mid-cycle.
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
        rsv_en = 1'b1; rsv_addr = 4'd2;
        tick();
        wr_en = 1'b0;
        tick();
        rsv_en = 1'b0;
        #1;
        chk("pre_rst_reg3", reg_data_b[3], 16'hBEEF);
        chk("pre_rst_busy", busy_mask_b, 16'h0004);
        chk("pre_rst_ovl", ovl_b, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_reg3", reg_data_b[3], 16'h0);
        chk("async_rst_busy", busy_mask_b, 16'h0);
        chk("async_rst_ovl", ovl_b, 1'b0);
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h1234;
        rsv_en = 1'b1; rsv_addr = 4'd4;
        tick();
        wr_en = 1'b0; rsv_en = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rst_discard_reg4", reg_data_b[4], 16'h0);
        chk("rst_discard_busy", busy_mask_b, 16'h0);

        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'h1000 + 16'(i);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd_addr[0] = 4'(i); rd_addr[1] = 4'(15 - i);
            #1;
            chk($sformatf("rd0_%0d", i), rd_data_b[0], 16'h1000 + 16'(i));
            chk($sformatf("rd1_%0d", i), rd_data_b[1], 16'h1000 + 16'(15 - i));
        end
        rd_addr[0] = 4'd6; rd_addr[1] = 4'd6;
        #1;
        chk("same_addr_p0", rd_data_b[0], 16'h1006);
        chk("same_addr_p1", rd_data_b[1], 16'h1006);
        chk("regdata_15", reg_data_b[15], 16'h100F);

        tick();
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h0001;
        tick();
        wr_data = 16'hA5A5; rd_addr[0] = 4'd5;
        #1;
        chk("bypass_on", rd_data_b[0], 16'hA5A5);
        chk("bypass_off", rd_data_n[0], 16'h0001);
        tick();
        wr_en = 1'b0;
        #1;
        chk("bypass_off_next", rd_data_n[0], 16'hA5A5);

        rsv_en = 1'b1; rsv_addr = 4'd7;
        tick();
        rsv_en = 1'b0; rd_addr[1] = 4'd7;
        #1;
        chk("rsv7_mask", busy_mask_b[7], 1'b1);
        chk("rsv7_rdbusy", rd_busy_b[1], 1'b1);
        chk("rsv7_rdbusy_p0", rd_busy_b[0], 1'b0);
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0042;
        #1;
        chk("wr7_busy_fwd", rd_busy_b[1], 1'b0);
        chk("wr7_busy_nofwd", rd_busy_n[1], 1'b1);
        chk("wr7_data_fwd", rd_data_b[1], 16'h0042);
        tick();
        wr_en = 1'b0;
        #1;
        chk("clr7_mask", busy_mask_b[7], 1'b0);
        chk("clr7_data", rd_data_n[1], 16'h0042);
        chk("clr7_rdbusy", rd_busy_n[1], 1'b0);

        rsv_en = 1'b1; rsv_addr = 4'd9;
        tick();
        chk("rsv9_first_ovl", ovl_b, 1'b0);
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h9999;
        tick();
        wr_en = 1'b0;
        chk("rw9_data", reg_data_b[9], 16'h9999);
        chk("rw9_busy", busy_mask_b[9], 1'b1);
        chk("rw9_ovl", ovl_b, 1'b0);
        tick();
        rsv_en = 1'b0;
        chk("rsv9_again_ovl", ovl_b, 1'b1);
        tick();
        chk("ovl_one_cycle", ovl_b, 1'b0);
        chk("busy9_held", busy_mask_b[9], 1'b1);
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h0909;
        tick();
        wr_en = 1'b0;
        chk("busy9_cleared", busy_mask_b[9], 1'b0);
        chk("busy_all_clear", busy_mask_b, 16'h0);

        // Wide variant: random traffic against an independent reference model.
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_busy = '0;
        m_ovl  = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            w_wr_en    = 1'($urandom_range(0, 1));
            w_wr_addr  = 3'($urandom_range(0, 7));
            w_wr_data  = $urandom;
            w_rsv_en   = ($urandom_range(0, 3) == 0);
            w_rsv_addr = 3'($urandom_range(0, 7));
            for (int n = 0; n < 3; n++) w_rd_addr[n] = 3'($urandom_range(0, 7));
            #1;
            for (int n = 0; n < 3; n++) begin
                m_fwd = w_wr_en && (w_rd_addr[n] == w_wr_addr);
                chk($sformatf("w_rd%0d_c%0d", n, c), w_rd_data[n], m_fwd ? w_wr_data : m_reg[w_rd_addr[n]]);
                chk($sformatf("w_bsy%0d_c%0d", n, c), w_rd_busy[n], m_fwd ? 1'b0 : m_busy[w_rd_addr[n]]);
            end
            chk($sformatf("w_mask_c%0d", c), w_busy_mask, m_busy);
            chk($sformatf("w_ovl_c%0d", c), w_ovl, m_ovl);
            chk($sformatf("w_reg_c%0d", c), w_reg_data[c % 8], m_reg[c % 8]);
            m_busy_nxt = m_busy;
            if (w_wr_en) m_busy_nxt[w_wr_addr] = 1'b0;
            if (w_rsv_en) m_busy_nxt[w_rsv_addr] = 1'b1;
            m_ovl = w_rsv_en && m_busy[w_rsv_addr] && !(w_wr_en && (w_wr_addr == w_rsv_addr));
            m_busy = m_busy_nxt;
            if (w_wr_en) m_reg[w_wr_addr] = w_wr_data;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
